// File: rtl/uart_interface.sv
// Host-side UART debug controller for the 5-stage pipeline: program load, run/step control and state dump.
// Define UART_IF_MEM_DUMP_EN to compile in dirty data-memory tracking and the memory section of the dump.
module uart_interface #(
    parameter int NB_DATA   = 8,
    parameter int NB_IF_ID  = 64,
    parameter int NB_ID_EX  = 144,
    parameter int NB_EX_MEM = 80,
    parameter int NB_MEM_WB = 72
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx_done,
    input  logic [NB_DATA-1:0]   i_rx_data,
    input  logic                 i_tx_done,
    output logic [NB_DATA-1:0]   o_tx_data,
    output logic                 o_tx_start,
    input  logic [31:0]          i_r_data_registers,
    input  logic [31:0]          i_r_data_data_mem,
    input  logic [NB_IF_ID-1:0]  i_IF_ID,
    input  logic [NB_ID_EX-1:0]  i_ID_EX,
    input  logic [NB_EX_MEM-1:0] i_EX_MEM,
    input  logic [NB_MEM_WB-1:0] i_MEM_WB,
    input  logic                 i_end,
    output logic                 o_reset_pipeline,
    output logic                 o_stop,
    output logic                 o_write_instruction_mem,
    output logic [31:0]          o_instruction_mem_addr,
    output logic [31:0]          o_instruction_mem_data,
    output logic [4:0]           o_r_addr_registers,
    output logic [4:0]           o_r_addr_data_mem
);
    localparam int NB_LAT = NB_IF_ID + NB_ID_EX + NB_EX_MEM + NB_MEM_WB;
    localparam logic [6:0] WORD_BYTES = 7'(32 / NB_DATA);
    localparam logic [6:0] LAT_BYTES  = 7'(NB_LAT / NB_DATA);

    localparam logic [NB_DATA-1:0] OP_LOAD      = NB_DATA'(0);
    localparam logic [NB_DATA-1:0] OP_START_CNT = NB_DATA'(1);
    localparam logic [NB_DATA-1:0] OP_START_DBG = NB_DATA'(2);
    localparam logic [NB_DATA-1:0] OP_STEP      = NB_DATA'(3);
    localparam logic [NB_DATA-1:0] OP_END_DBG   = NB_DATA'(4);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DEBUG = 3'd3;
    localparam logic [2:0] ST_STEP  = 3'd4;
    localparam logic [2:0] ST_SEND  = 3'd5;

    localparam logic [1:0] PH_MEM = 2'd0;
    localparam logic [1:0] PH_REG = 2'd1;
    localparam logic [1:0] PH_LAT = 2'd2;

    localparam logic [2:0] SB_SCAN  = 3'd0;
    localparam logic [2:0] SB_ADDR  = 3'd1;
    localparam logic [2:0] SB_SAMP  = 3'd2;
    localparam logic [2:0] SB_START = 3'd3;
    localparam logic [2:0] SB_WAIT  = 3'd4;

    logic [2:0]         state_q, state_d, ret_q, ret_d;
    logic [1:0]         ph_q, ph_d;
    logic [2:0]         sb_q, sb_d;
    logic [4:0]         idx_q, idx_d;
    logic [6:0]         left_q, left_d;
    logic [NB_LAT-1:0]  shift_q, shift_d;
    logic [31:0]        word_q, word_d, waddr_q, waddr_d;
    logic [1:0]         bcnt_q, bcnt_d;
    logic               rx_prev_q, rx_pulse;
    logic [31:0]        dirty_q;
    logic [NB_DATA-1:0] tx_data_d;
    logic               tx_start_d, wr_d, rst_pipe_d, stop_d;
    logic [31:0]        iaddr_d, idata_d;
    logic [4:0]         raddr_reg_d, raddr_mem_d;

    assign rx_pulse = i_rx_done & ~rx_prev_q;

`ifdef UART_IF_MEM_DUMP_EN
    localparam logic [1:0] PH_FIRST = PH_MEM;
    localparam logic [2:0] SB_FIRST = SB_SCAN;

    // ALU_result[6:2] sits at EX_MEM[13:9]; MEM_write is bit 3.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            dirty_q <= '0;
        else if (state_q == ST_SEND && state_d != ST_SEND)
            dirty_q <= '0;
        else if (!o_stop && i_EX_MEM[3])
            dirty_q[i_EX_MEM[13:9]] <= 1'b1;
    end
`else
    localparam logic [1:0] PH_FIRST = PH_REG;
    localparam logic [2:0] SB_FIRST = SB_ADDR;
    assign dirty_q = '0;
`endif

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        ph_d        = ph_q;
        sb_d        = sb_q;
        idx_d       = idx_q;
        left_d      = left_q;
        shift_d     = shift_q;
        word_d      = word_q;
        bcnt_d      = bcnt_q;
        waddr_d     = waddr_q;
        tx_data_d   = o_tx_data;
        tx_start_d  = 1'b0;
        wr_d        = 1'b0;
        iaddr_d     = o_instruction_mem_addr;
        idata_d     = o_instruction_mem_data;
        raddr_reg_d = o_r_addr_registers;
        raddr_mem_d = o_r_addr_data_mem;
        case (state_q)
            ST_IDLE: if (rx_pulse) begin
                case (i_rx_data)
                    OP_LOAD: begin
                        state_d = ST_LOAD;
                        waddr_d = '0;
                        iaddr_d = '0;
                        bcnt_d  = '0;
                    end
                    OP_START_CNT: state_d = ST_RUN;
                    OP_START_DBG: state_d = ST_DEBUG;
                    default: ;
                endcase
            end
            ST_LOAD: if (rx_pulse) begin
                word_d = {word_q[31-NB_DATA:0], i_rx_data};
                bcnt_d = bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) begin
                    wr_d    = 1'b1;
                    iaddr_d = waddr_q;
                    idata_d = word_d;
                    waddr_d = waddr_q + 32'd4;
                    if (word_d == 32'hFFFF_FFFF)
                        state_d = ST_IDLE;
                end
            end
            ST_RUN: if (i_end) begin
                state_d = ST_SEND;
                ret_d   = ST_IDLE;
                ph_d    = PH_FIRST;
                sb_d    = SB_FIRST;
                idx_d   = '0;
            end
            ST_DEBUG: if (rx_pulse) begin
                if (i_rx_data == OP_STEP)
                    state_d = ST_STEP;
                else if (i_rx_data == OP_END_DBG)
                    state_d = ST_IDLE;
            end
            ST_STEP: begin
                state_d = ST_SEND;
                ret_d   = ST_DEBUG;
                ph_d    = PH_FIRST;
                sb_d    = SB_FIRST;
                idx_d   = '0;
            end
            ST_SEND: begin
                case (sb_q)
                    SB_SCAN: begin
                        if (dirty_q[idx_q]) begin
                            sb_d = SB_ADDR;
                        end else if (idx_q == 5'd31) begin
                            ph_d  = PH_REG;
                            idx_d = '0;
                            sb_d  = SB_ADDR;
                        end else begin
                            idx_d = idx_q + 5'd1;
                        end
                    end
                    SB_ADDR: begin
                        if (ph_q == PH_MEM) raddr_mem_d = idx_q;
                        else                raddr_reg_d = idx_q;
                        sb_d = SB_SAMP;
                    end
                    // Read data is valid one cycle after the address register updates.
                    SB_SAMP: begin
                        case (ph_q)
                            PH_MEM: begin
                                shift_d = {i_r_data_data_mem, {(NB_LAT-32){1'b0}}};
                                left_d  = WORD_BYTES;
                            end
                            PH_REG: begin
                                shift_d = {i_r_data_registers, {(NB_LAT-32){1'b0}}};
                                left_d  = WORD_BYTES;
                            end
                            default: begin
                                shift_d = {i_IF_ID, i_ID_EX, i_EX_MEM, i_MEM_WB};
                                left_d  = LAT_BYTES;
                            end
                        endcase
                        sb_d = SB_START;
                    end
                    SB_START: begin
                        tx_data_d  = shift_q[NB_LAT-1 -: NB_DATA];
                        tx_start_d = 1'b1;
                        shift_d    = shift_q << NB_DATA;
                        left_d     = left_q - 7'd1;
                        sb_d       = SB_WAIT;
                    end
                    default: if (i_tx_done) begin
                        if (left_q != 7'd0) begin
                            sb_d = SB_START;
                        end else begin
                            case (ph_q)
                                PH_MEM: begin
                                    if (idx_q == 5'd31) begin
                                        ph_d  = PH_REG;
                                        idx_d = '0;
                                        sb_d  = SB_ADDR;
                                    end else begin
                                        idx_d = idx_q + 5'd1;
                                        sb_d  = SB_SCAN;
                                    end
                                end
                                PH_REG: begin
                                    if (idx_q == 5'd31) begin
                                        ph_d = PH_LAT;
                                        sb_d = SB_SAMP;
                                    end else begin
                                        idx_d = idx_q + 5'd1;
                                        sb_d  = SB_ADDR;
                                    end
                                end
                                default: state_d = ret_q;
                            endcase
                        end
                    end
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
        rst_pipe_d = (state_d == ST_IDLE);
        stop_d     = !(state_d == ST_RUN || state_d == ST_STEP);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q                 <= ST_IDLE;
            ret_q                   <= ST_IDLE;
            ph_q                    <= PH_REG;
            sb_q                    <= SB_ADDR;
            idx_q                   <= '0;
            left_q                  <= '0;
            shift_q                 <= '0;
            word_q                  <= '0;
            bcnt_q                  <= '0;
            waddr_q                 <= '0;
            rx_prev_q               <= 1'b0;
            o_tx_data               <= '0;
            o_tx_start              <= 1'b0;
            o_write_instruction_mem <= 1'b0;
            o_instruction_mem_addr  <= '0;
            o_instruction_mem_data  <= '0;
            o_r_addr_registers      <= '0;
            o_r_addr_data_mem       <= '0;
            o_reset_pipeline        <= 1'b1;
            o_stop                  <= 1'b1;
        end else begin
            state_q                 <= state_d;
            ret_q                   <= ret_d;
            ph_q                    <= ph_d;
            sb_q                    <= sb_d;
            idx_q                   <= idx_d;
            left_q                  <= left_d;
            shift_q                 <= shift_d;
            word_q                  <= word_d;
            bcnt_q                  <= bcnt_d;
            waddr_q                 <= waddr_d;
            rx_prev_q               <= i_rx_done;
            o_tx_data               <= tx_data_d;
            o_tx_start              <= tx_start_d;
            o_write_instruction_mem <= wr_d;
            o_instruction_mem_addr  <= iaddr_d;
            o_instruction_mem_data  <= idata_d;
            o_r_addr_registers      <= raddr_reg_d;
            o_r_addr_data_mem       <= raddr_mem_d;
            o_reset_pipeline        <= rst_pipe_d;
            o_stop                  <= stop_d;
        end
    end
endmodule

// File: tb/tb_uart_interface.sv
// Directed-sequence bench for uart_interface with randomized data and a byte-stream reference model.
module tb_uart_interface;
`ifdef UART_IF_MEM_DUMP_EN
    localparam bit MEM_EN = 1'b1;
`else
    localparam bit MEM_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         i_reset, i_rx_done, i_tx_done, i_end;
    logic [7:0]   i_rx_data, o_tx_data;
    logic         o_tx_start, o_reset_pipeline, o_stop, o_write_instruction_mem;
    logic [31:0]  i_r_data_registers, i_r_data_data_mem;
    logic [31:0]  o_instruction_mem_addr, o_instruction_mem_data;
    logic [4:0]   o_r_addr_registers, o_r_addr_data_mem;
    logic [63:0]  if_id;
    logic [143:0] id_ex;
    logic [79:0]  ex_mem;
    logic [71:0]  mem_wb;

    logic [31:0]  regs [32];
    logic [31:0]  dmem [32];
    bit           dirty_m [32];
    logic [7:0]   exp_q [$];
    int           n_vec = 0, n_err = 0, n_total = 0;
    int           wr_cnt = 0, stop_low = 0;
    logic [31:0]  wr_addr, wr_data;

    always #5 clk = ~clk;

    assign i_r_data_registers = regs[o_r_addr_registers];
    assign i_r_data_data_mem  = dmem[o_r_addr_data_mem];

    uart_interface dut (
        .i_clk(clk), .i_reset(i_reset), .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
        .i_tx_done(i_tx_done), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
        .i_r_data_registers(i_r_data_registers), .i_r_data_data_mem(i_r_data_data_mem),
        .i_IF_ID(if_id), .i_ID_EX(id_ex), .i_EX_MEM(ex_mem), .i_MEM_WB(mem_wb),
        .i_end(i_end), .o_reset_pipeline(o_reset_pipeline), .o_stop(o_stop),
        .o_write_instruction_mem(o_write_instruction_mem),
        .o_instruction_mem_addr(o_instruction_mem_addr),
        .o_instruction_mem_data(o_instruction_mem_data),
        .o_r_addr_registers(o_r_addr_registers), .o_r_addr_data_mem(o_r_addr_data_mem)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_vec++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (o_write_instruction_mem) begin
            wr_cnt++;
            wr_addr = o_instruction_mem_addr;
            wr_data = o_instruction_mem_data;
        end
        if (!o_stop) stop_low++;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        i_rx_data = b;
        i_rx_done = 1'b1;
        repeat (hold) tick();
        i_rx_done = 1'b0;
        tick();
    endtask

    task automatic load_word(input logic [31:0] w, input int k);
        for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8], (b == 1) ? 3 : 1);
        chk("load_wr_cnt", 64'(wr_cnt), 64'(k + 1));
        chk("load_wr_addr", wr_addr, 64'(4 * k));
        chk("load_wr_data", wr_data, w);
    endtask

    function automatic logic [79:0] mk_ex_mem(input logic [31:0] alu, input bit memw);
        return {4'b0, 5'($urandom), $urandom, alu, 3'($urandom), memw, 3'($urandom)};
    endfunction

    task automatic build_expect();
        logic [359:0] l;
        exp_q.delete();
        for (int i = 0; i < 32; i++)
            if (MEM_EN && dirty_m[i])
                for (int b = 3; b >= 0; b--) exp_q.push_back(dmem[i][8*b +: 8]);
        for (int i = 0; i < 32; i++)
            for (int b = 3; b >= 0; b--) exp_q.push_back(regs[i][8*b +: 8]);
        l = {if_id, id_ex, ex_mem, mem_wb};
        for (int k = 44; k >= 0; k--) exp_q.push_back(l[8*k +: 8]);
        n_total = exp_q.size();
        for (int i = 0; i < 32; i++) dirty_m[i] = 1'b0;
    endtask

    task automatic collect_dump();
        int got = 0, guard, extra = 0;
        bit timed_out = 1'b0;
        logic [7:0] b;
        while (exp_q.size() > 0 && !timed_out) begin
            guard = 0;
            while (!o_tx_start && guard < 400) begin
                tick();
                guard++;
            end
            if (!o_tx_start) begin
                chk("dump_byte_count", 64'(got), 64'(n_total));
                timed_out = 1'b1;
            end else begin
                b = exp_q.pop_front();
                chk("dump_byte", o_tx_data, b);
                chk("dump_stop", o_stop, 1);
                got++;
                tick();
                chk("tx_start_one_cycle", o_tx_start, 0);
                repeat ($urandom_range(0, 3)) tick();
                i_tx_done = 1'b1;
                tick();
                i_tx_done = 1'b0;
            end
        end
        if (!timed_out) begin
            chk("dump_byte_count", 64'(got), 64'(n_total));
            repeat (60) begin
                tick();
                if (o_tx_start) extra++;
            end
            chk("no_extra_tx", 64'(extra), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] w, alu;
        bit memw;
        int guard;
        i_reset = 1'b1; i_rx_done = 1'b0; i_rx_data = '0; i_tx_done = 1'b0; i_end = 1'b0;
        if_id = {$urandom, $urandom};
        for (int i = 0; i < 144; i += 16) id_ex[i +: 16] = 16'($urandom);
        mem_wb = {8'($urandom), $urandom, $urandom};
        ex_mem = '0;
        for (int i = 0; i < 32; i++) begin
            regs[i] = $urandom;
            dmem[i] = $urandom;
            dirty_m[i] = 1'b0;
        end
        repeat (2) tick();
        chk("rst_reset_pipeline", o_reset_pipeline, 1);
        chk("rst_stop", o_stop, 1);
        chk("rst_tx_start", o_tx_start, 0);
        chk("rst_tx_data", o_tx_data, 0);
        chk("rst_wr_en", o_write_instruction_mem, 0);
        chk("rst_imem_addr", o_instruction_mem_addr, 0);
        i_reset = 1'b0;
        tick();

        send_byte(8'h07, 1);
        chk("unknown_op_idle", {o_reset_pipeline, o_stop}, 2'b11);
        send_byte(8'h03, 1);
        chk("step_in_idle_ignored", 64'(stop_low), 0);

        send_byte(8'h00, 1);
        chk("load_reset_pipeline", o_reset_pipeline, 0);
        chk("load_stop", o_stop, 1);
        load_word(32'h0102_0304, 0);
        for (int k = 1; k < 3; k++) begin
            w = $urandom;
            if (w == 32'hFFFF_FFFF) w = 32'h1234_5678;
            load_word(w, k);
            chk("load_stays_loading", o_reset_pipeline, 0);
        end
        load_word(32'hFFFF_FFFF, 3);
        chk("halt_back_idle", o_reset_pipeline, 1);
        tick();
        chk("single_write_pulse", o_write_instruction_mem, 0);

        send_byte(8'h01, 1);
        chk("run_stop", o_stop, 0);
        chk("run_reset_pipeline", o_reset_pipeline, 0);
        for (int s = 0; s < 4; s++) begin
            alu = (s == 0) ? 32'h0000_000F : (s == 1) ? 32'h0000_0013 : $urandom;
            memw = (s < 3) ? 1'b1 : 1'b0;
            ex_mem = mk_ex_mem(alu, memw);
            if (memw) dirty_m[alu[6:2]] = 1'b1;
            tick();
        end
        ex_mem = mk_ex_mem($urandom, 1'b0);
        i_end = 1'b1;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!o_stop && guard < 4);
        i_end = 1'b0;
        chk("end_stops_pipeline", o_stop, 1);
        chk("end_stop_latency_ok", 64'(guard <= 2), 1);
        build_expect();
        collect_dump();
        chk("run_dump_returns_idle", o_reset_pipeline, 1);

        stop_low = 0;
        send_byte(8'h02, 3);
        tick();
        chk("debug_stop", o_stop, 1);
        chk("debug_reset_pipeline", o_reset_pipeline, 0);
        chk("debug_no_step", 64'(stop_low), 0);
        send_byte(8'h01, 1);
        chk("debug_ignores_other", {o_reset_pipeline, o_stop}, 2'b01);

        stop_low = 0;
        send_byte(8'h03, 1);
        build_expect();
        collect_dump();
        chk("step_one_cycle", 64'(stop_low), 1);
        chk("step_back_debug", {o_reset_pipeline, o_stop}, 2'b01);

        send_byte(8'h04, 1);
        chk("end_debug_idle", {o_reset_pipeline, o_stop}, 2'b11);

        send_byte(8'h01, 1);
        i_end = 1'b1;
        tick();
        i_end = 1'b0;
        guard = 0;
        while (!o_tx_start && guard < 400) begin
            tick();
            guard++;
        end
        chk("midreset_dump_started", o_tx_start, 1);
        i_reset = 1'b1;
        #2;
        chk("async_rst_tx_start", o_tx_start, 0);
        chk("async_rst_state", {o_reset_pipeline, o_stop}, 2'b11);
        chk("async_rst_tx_data", o_tx_data, 0);
        chk("async_rst_raddr", o_r_addr_registers, 0);
        tick();
        i_reset = 1'b0;
        guard = 0;
        repeat (40) begin
            i_tx_done = 1'b1;
            tick();
            if (o_tx_start) guard++;
        end
        i_tx_done = 1'b0;
        chk("dump_aborted", 64'(guard), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
